// File: rtl/t_ff_pkg.sv
// Shared types for the toggle flip-flop bank.
// Mode select encoding and its width.
package t_ff_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_TOGGLE = 2'd0,
    MODE_COUNT  = 2'd1,
    MODE_LOAD   = 2'd2,
    MODE_CLEAR  = 2'd3
  } mode_e;

endpackage

// File: rtl/t_ff_cell.sv
// Single-bit edge-triggered T flip-flop with sync reset and load.
// Ports: clk, rst_n, rst_val, en, load, load_val, tog -> q.
module t_ff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val,
  input  logic en,
  input  logic load,
  input  logic load_val,
  input  logic tog,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      if (load) q_d = load_val;
      else if (tog) q_d = ~q_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= rst_val;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/t_ff_bank.sv
// WIDTH-bit bank of T flip-flops: toggle, count, load or clear.
// Ports: clk, rst_n, en, mode, t, d -> q, q_bar, wrap, changed.
module t_ff_bank
  import t_ff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  t,
  input  logic [WIDTH-1:0]  d,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  q_bar,
  output logic              wrap,
  output logic              changed
);

  logic [WIDTH-1:0] carry;
  logic             all_ones;
  logic [WIDTH-1:0] load_v;
  logic [WIDTH-1:0] lval_v;
  logic [WIDTH-1:0] tog_v;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_q, wrap_d;
  logic             chg_q, chg_d;
  mode_e            mode_s;

  assign mode_s = mode_e'(mode);

  // carry[i] is high when every bit below i is one
  always_comb begin
    carry    = '0;
    all_ones = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i] = all_ones;
      all_ones = all_ones & q[i];
    end
  end

  always_comb begin
    load_v = '0;
    lval_v = d;
    tog_v  = '0;
    unique case (mode_s)
      MODE_TOGGLE: tog_v = t;
      MODE_COUNT:  tog_v = t[0] ? carry : '0;
      MODE_LOAD: begin
        load_v = '1;
        lval_v = d;
      end
      MODE_CLEAR: begin
        load_v = '1;
        lval_v = RESET_VAL;
      end
      default: ;
    endcase
  end

  // mirror of what the cells will hold after this edge
  assign q_nxt = (load_v & lval_v) | (~load_v & (q ^ tog_v));

  assign wrap_d = en && (mode_s == MODE_COUNT) && t[0] && all_ones;
  assign chg_d  = en && (q_nxt != q);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .rst_val  (RESET_VAL[i]),
      .en       (en),
      .load     (load_v[i]),
      .load_val (lval_v[i]),
      .tog      (tog_v[i]),
      .q        (q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
      chg_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      chg_q  <= chg_d;
    end
  end

  assign q_bar   = ~q;
  assign wrap    = wrap_q;
  assign changed = chg_q;

endmodule

// File: doc/t_ff_bank.md
# t_ff_bank

Parametrised, clocked bank of WIDTH toggle flip-flops with a shared mode select: per-bit toggle, chained binary up-count, parallel load, or clear. It supersedes the single-bit level-sensitive T latch: it is edge-triggered, multi-bit and resettable to a parameter value, and it reports counter wrap and state change. It sits in the behavioural library as the standard toggle/counter primitive for divider and event-flag logic.

## Interface
- WIDTH, 8: number of flip-flops, at least 1.
- RESET_VAL, '0: value of q after reset and after a clear; WIDTH bits wide.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low; it has priority over every other input.
- en  in  1  update enable; when 0 all state holds, whatever the mode.
- mode  in  2  operation select: TOGGLE=0, COUNT=1, LOAD=2, CLEAR=3.
- t  in  WIDTH  per-bit toggle request (TOGGLE mode); t[0] is the count enable in COUNT mode.
- d  in  WIDTH  parallel load data (LOAD mode).
- q  out  WIDTH  registered state.
- q_bar  out  WIDTH  bitwise complement of q, derived combinationally from the register.
- wrap  out  1  registered one-cycle pulse: the counter rolled over from all-ones to zero.
- changed  out  1  registered one-cycle pulse: q took a different value on the last edge.

## Operation
- Reset (rst_n=0 at the edge): q=RESET_VAL, q_bar=~RESET_VAL, wrap=0, changed=0.
- en=0: q holds; wrap=0 and changed=0 on the next edge.
- TOGGLE: q <= q ^ t. With t=0 the bits hold, which matches the T-latch truth table per bit.
- COUNT: if t[0]=1 then q <= q+1, modulo 2^WIDTH. Bit i toggles when all bits below i are 1. If t[0]=0, q holds. t[WIDTH-1:1] are ignored.
- LOAD: q <= d.
- CLEAR: q <= RESET_VAL. This is a synchronous clear gated by en, distinct from rst_n.
- wrap: set to 1 for one cycle only on an edge where mode=COUNT, en=1, t[0]=1 and q was all-ones. Toggling or loading to zero never raises wrap.
- changed: set to 1 for one cycle when the next q differs from the current q, in any mode.
- WIDTH=1, COUNT: behaves as a T flip-flop on t[0]; wrap pulses on every 1->0 transition.

## Timing
- q updates one edge after inputs are sampled, so there is one-cycle latency. q_bar follows q in the same cycle with zero added latency.
- wrap and changed are registered alongside q and are valid in the same cycle as the q they describe.
- mode, t, d and en are sampled only at the rising edge. There are no internal delays and no # delays.
- Reset in the middle of a count: the next edge forces RESET_VAL, and any wrap or changed pulse pending for that edge is suppressed.
- Simultaneous events: rst_n=0 wins over everything; en=0 wins over mode.

## Structure
- Package t_ff_pkg holds the mode enum (MODE_TOGGLE, MODE_COUNT, MODE_LOAD, MODE_CLEAR) and a mode width constant of 2.
- Sub-module t_ff_cell is the single-bit flip-flop. Inputs: clk, rst_n, rst_val, en, load, load_val, tog. Output: q. The bank instantiates WIDTH of these through a generate loop.
- The top level computes each cell's load and tog signals from mode, t, d and the carry chain, and holds the wrap and changed registers.

## Test plan
- Reset: WIDTH=8, RESET_VAL=8'hA5, hold rst_n=0 for 2 edges -> q=8'hA5, q_bar=8'h5A, wrap=0, changed=0.
- Toggle: q=8'h00, mode=TOGGLE, en=1, t=8'h0F for 1 edge -> q=8'h0F, changed=1. Next edge with t=8'h00 -> q=8'h0F, changed=0.
- Count and wrap: LOAD d=8'hFD, then COUNT with t[0]=1 for 3 edges -> q goes FE, FF, 00. wrap=1 only in the cycle q=00.
- Enable gating: COUNT, t[0]=1, en=0 for 5 edges -> q unchanged, wrap=0, changed=0.
- Clear versus reset: q=8'h33, mode=CLEAR, en=1 -> q=RESET_VAL. Then with en=1, COUNT, t[0]=1 and rst_n=0 on the same edge -> q=RESET_VAL and wrap=0.
- WIDTH=1 instance: COUNT, t[0]=1 for 4 edges -> q goes 1, 0, 1, 0; wrap pulses on both 1->0 edges.
